crossbar_rr_fifo: RTL and testbench
===================================

# crossbar_rr_fifo

Parametrised N-port packet crossbar for the NoC router datapath. Each input has a DEPTH-entry FIFO, and each output has its own round-robin arbiter with wormhole packet locking. Every link uses a valid/ready handshake, and each output is a registered slot. It supersedes the unbuffered crossbar, whose priority rotated every clock and which had no flow control.

## Interface
- PORTS, 4, number of input and output ports; ≥2, power of 2
- WIDTH, 8, flit payload width
- DEPTH, 4, entries per input FIFO; ≥2, power of 2
- DW, $clog2(PORTS), derived width of the destination field
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_data[PORTS]  in  WIDTH  flit payload
- in_dest[PORTS]  in  DW  destination output index
- in_last[PORTS]  in  1  flit is the final flit of its packet
- in_valid[PORTS]  in  1  flit offered
- in_ready[PORTS]  out  1  FIFO can accept; equals count<DEPTH, taken from the registered count
- out_data[PORTS]  out  WIDTH  registered flit payload
- out_last[PORTS]  out  1  registered last flag
- out_valid[PORTS]  out  1  output slot holds a flit
- out_ready[PORTS]  in  1  downstream accepts

## Operation
- Input write: when in_valid[i]&&in_ready[i], {dest,last,data} is pushed into FIFO i. Offers while in_ready=0 are ignored and never stored.
- Input request: each non-empty FIFO requests only the output named in its head entry's dest field.
- Per-output state: rr_ptr[o] (DW bits), lock[o] (1 bit), owner[o] (DW bits).
- Arbitration when lock[o]=0:
  - Scan the inputs rr_ptr[o], rr_ptr[o]+1, … mod PORTS.
  - The first requesting input wins.
- Arbitration when lock[o]=1:
  - Only owner[o] is eligible.
  - If FIFO owner[o] is empty or its head targets another output, output o idles; no other input may be granted.
- Slot load: the output slot accepts a flit when out_valid[o]=0 or out_ready[o]=1.
- Transfer: happens when a winner exists and the slot accepts. On that edge:
  - The winner's FIFO pops.
  - The slot loads {data,last} and out_valid[o] is set to 1.
- After a transfer with last=0:
  - lock[o]<=1 and owner[o]<=winner.
  - rr_ptr[o] is unchanged.
- After a transfer with last=1:
  - lock[o]<=0.
  - rr_ptr[o]<=(winner+1) mod PORTS, so priority moves to the input after the one just served.
- Slot drain: out_ready[o]&&out_valid[o] with no transfer in the same cycle clears out_valid[o]. out_data and out_last hold their last values.
- Pop uniqueness: each input has one head, so it is granted by at most one output per cycle, and a FIFO pops at most once per cycle.
- Packet rule: upstream keeps in_dest constant within a packet. The bench asserts this; the RTL does not check it.
- FIFO count arithmetic: count is $clog2(DEPTH)+1 bits, and pointers wrap modulo DEPTH.
  - Push and pop in the same cycle: count unchanged.
  - Push only: count+1. Pop only: count-1.
  - There is no bypass: a full FIFO popped this cycle shows in_ready=1 only from the next cycle.

## Timing
- Reset values, asynchronous and held while rst=1:
  - All FIFOs empty (count=0), so in_ready=1 for all ports.
  - out_valid=0, out_data=0, out_last=0.
  - rr_ptr=0, lock=0, owner=0.
- Reset mid-packet discards all buffered flits and clears every lock.
- Latency: a flit pushed at edge t into an empty FIFO with an idle, unlocked output appears at out_valid/out_data after edge t+1 (2-cycle minimum, input handshake to output valid).
- Throughput: 1 flit/cycle per output under continuous out_ready=1. Different outputs run concurrently.
- Backpressure:
  - out_ready=0 with out_valid=1 holds the slot stable, with no change to data or last.
  - The FIFO fills and in_ready drops after DEPTH accepted flits.
- All outputs are registered or derived from registered count only; there are no combinational paths from inputs to outputs.

## Test plan
- Reset/idle: assert rst asynchronously mid-cycle -> out_valid=0, in_ready=4'b1111 immediately; after release, no out_valid for 10 idle cycles.
- Single flit: port 2 sends data=8'hA5, dest=1, last=1 -> out_valid[1]=1, out_data[1]=8'hA5 two edges after the handshake; FIFOs 0, 1 and 3 are untouched.
- Round-robin fairness: inputs 0–3 each stream 1-flit packets to output 0, out_ready=1 -> grant order 0,1,2,3,0,… with one flit per cycle and none skipped.
- Wormhole lock:
  - Stimulus: input 1 sends a 3-flit packet (11,12,13, last on 13) to output 3 while input 2 continuously requests output 3.
  - Required: output 3 carries 11,12,13 contiguously, then input 2's flit.
  - Stimulus: stall input 1 for 2 cycles mid-packet.
  - Required: output 3 idles and does not grant input 2.
- Backpressure/full: hold out_ready[0]=0, input 0 streams to output 0 -> in_ready[0] falls after 1 (slot) + 4 (FIFO) flits; releasing out_ready delivers all 5 flits in order with none lost or duplicated.
- Concurrent permutation: inputs 0,1,2,3 send to outputs 3,2,1,0 simultaneously -> all four outputs valid on the same cycle, with 4 flits/cycle sustained.

Source files
------------

// File: rtl/crossbar_rr_fifo.sv
// rtl/crossbar_rr_fifo.sv - N-port buffered packet crossbar: per-input FIFOs,
// per-output round-robin arbitration with wormhole locking, registered output slots.
module crossbar_rr_fifo #(
   parameter int PORTS = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int DW    = $clog2(PORTS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data   [PORTS],
   input  logic [DW-1:0]    in_dest   [PORTS],
   input  logic             in_last   [PORTS],
   input  logic             in_valid  [PORTS],
   output logic             in_ready  [PORTS],
   output logic [WIDTH-1:0] out_data  [PORTS],
   output logic             out_last  [PORTS],
   output logic             out_valid [PORTS],
   input  logic             out_ready [PORTS]
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DW + 1 + WIDTH;

   logic [EW-1:0]    mem       [PORTS][DEPTH];
   logic [AW-1:0]    wr_ptr    [PORTS];
   logic [AW-1:0]    rd_ptr    [PORTS];
   logic [CW-1:0]    count     [PORTS];
   logic [EW-1:0]    head      [PORTS];
   logic [DW-1:0]    head_dest [PORTS];
   logic             head_last [PORTS];
   logic [WIDTH-1:0] head_data [PORTS];
   logic             push      [PORTS];
   logic             pop       [PORTS];
   logic             req       [PORTS][PORTS];

   logic [DW-1:0]    rr_ptr    [PORTS];
   logic [DW-1:0]    owner     [PORTS];
   logic             lock      [PORTS];
   logic [DW-1:0]    winner    [PORTS];
   logic             win_vld   [PORTS];
   logic             xfer      [PORTS];

   always_comb begin
      for (int i = 0; i < PORTS; i++) begin
         in_ready[i] = count[i] < CW'(DEPTH);
         push[i]     = in_valid[i] && in_ready[i];
         head[i]     = mem[i][rd_ptr[i]];
         {head_dest[i], head_last[i], head_data[i]} = head[i];
      end
   end

   // Each input requests only the output named by its head flit.
   always_comb begin
      for (int i = 0; i < PORTS; i++) begin
         for (int o = 0; o < PORTS; o++) begin
            req[i][o] = (count[i] != '0) && (head_dest[i] == DW'(o));
         end
      end
   end

   // Reverse scan so the candidate closest to rr_ptr is assigned last and wins.
   always_comb begin
      for (int o = 0; o < PORTS; o++) begin
         winner[o]  = rr_ptr[o];
         win_vld[o] = 1'b0;
         if (lock[o]) begin
            winner[o]  = owner[o];
            win_vld[o] = req[owner[o]][o];
         end else begin
            for (int k = PORTS - 1; k >= 0; k--) begin
               if (req[rr_ptr[o] + DW'(k)][o]) begin
                  winner[o]  = rr_ptr[o] + DW'(k);
                  win_vld[o] = 1'b1;
               end
            end
         end
         xfer[o] = win_vld[o] && (!out_valid[o] || out_ready[o]);
      end
   end

   always_comb begin
      for (int i = 0; i < PORTS; i++) begin
         pop[i] = 1'b0;
         for (int o = 0; o < PORTS; o++) begin
            if (xfer[o] && (winner[o] == DW'(i))) pop[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PORTS; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < PORTS; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
            if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
            else if (!push[i] && pop[i]) count[i] <= count[i] - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < PORTS; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= {in_dest[i], in_last[i], in_data[i]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int o = 0; o < PORTS; o++) begin
            out_valid[o] <= 1'b0;
            out_data[o]  <= '0;
            out_last[o]  <= 1'b0;
            rr_ptr[o]    <= '0;
            lock[o]      <= 1'b0;
            owner[o]     <= '0;
         end
      end else begin
         for (int o = 0; o < PORTS; o++) begin
            if (xfer[o]) begin
               out_valid[o] <= 1'b1;
               out_data[o]  <= head_data[winner[o]];
               out_last[o]  <= head_last[winner[o]];
               if (head_last[winner[o]]) begin
                  lock[o]   <= 1'b0;
                  rr_ptr[o] <= winner[o] + DW'(1);
               end else begin
                  lock[o]   <= 1'b1;
                  owner[o]  <= winner[o];
               end
            end else if (out_ready[o]) begin
               out_valid[o] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_crossbar_rr_fifo.sv
// tb/tb_crossbar_rr_fifo.sv - directed scoreboard bench for crossbar_rr_fifo.
module tb_crossbar_rr_fifo;
   localparam int P  = 4;
   localparam int W  = 8;
   localparam int DW = 2;

   typedef struct packed {
      logic          gap;
      logic [DW-1:0] dest;
      logic          last;
      logic [W-1:0]  data;
   } flit_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  in_data   [P];
   logic [DW-1:0] in_dest   [P];
   logic          in_last   [P];
   logic          in_valid  [P];
   logic          in_ready  [P];
   logic [W-1:0]  out_data  [P];
   logic          out_last  [P];
   logic          out_valid [P];
   logic          out_ready [P];

   logic [3:0]    ir_vec, ov_vec;
   flit_t         src_q [P][$];
   logic [8:0]    exp_q [P][$];
   int            n_cmp = 0, n_fail = 0, cyc = 0, allv_cnt = 0;
   int            acc_cnt [P], hs_cnt [P], first_cyc [P], last_cyc [P];
   logic          acc [P], gap_drv [P], in_pkt [P];
   logic [DW-1:0] pkt_dest [P];

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < P; i++) begin
         ir_vec[i] = in_ready[i];
         ov_vec[i] = out_valid[i];
      end
   end

   crossbar_rr_fifo #(.PORTS(P), .WIDTH(W), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int i, input logic [W-1:0] d, input int dst, input logic l);
      flit_t f;
      f.gap  = 1'b0;
      f.dest = DW'(dst);
      f.last = l;
      f.data = d;
      src_q[i].push_back(f);
      exp_q[dst].push_back({l, d});
   endtask

   task automatic gap(input int i);
      flit_t f;
      f = '0;
      f.gap = 1'b1;
      src_q[i].push_back(f);
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < P; i++) s += src_q[i].size() + exp_q[i].size();
      return s;
   endfunction

   task automatic clr_stats();
      allv_cnt = 0;
      for (int i = 0; i < P; i++) begin
         acc_cnt[i] = 0; hs_cnt[i] = 0; first_cyc[i] = 0; last_cyc[i] = 0;
      end
   endtask

   // One clock: monitor/scoreboard at negedge, drive new inputs 1 time unit after posedge.
   task automatic step();
      logic [8:0] e;
      flit_t      f;
      @(negedge clk);
      if (ov_vec == 4'hF) allv_cnt++;
      for (int o = 0; o < P; o++) begin
         if (out_valid[o] && out_ready[o]) begin
            hs_cnt[o]++;
            if (hs_cnt[o] == 1) first_cyc[o] = cyc;
            last_cyc[o] = cyc;
            if (exp_q[o].size() == 0) begin
               check($sformatf("unexpected_out%0d", o), exp_q[o].size(), 1);
            end else begin
               e = exp_q[o].pop_front();
               check($sformatf("out%0d_flit", o), {out_last[o], out_data[o]}, e);
            end
         end
      end
      for (int i = 0; i < P; i++) begin
         acc[i] = in_valid[i] && in_ready[i];
         if (acc[i]) begin
            acc_cnt[i]++;
            if (in_pkt[i]) check($sformatf("pkt_dest_in%0d", i), in_dest[i], pkt_dest[i]);
            pkt_dest[i] = in_dest[i];
            in_pkt[i]   = !in_last[i];
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < P; i++) begin
         if ((acc[i] || gap_drv[i]) && src_q[i].size() > 0) f = src_q[i].pop_front();
         gap_drv[i] = 1'b0;
         in_valid[i] = 1'b0;
         if (src_q[i].size() > 0) begin
            f = src_q[i][0];
            if (f.gap) begin
               gap_drv[i] = 1'b1;
            end else begin
               in_valid[i] = 1'b1;
               in_data[i]  = f.data;
               in_dest[i]  = f.dest;
               in_last[i]  = f.last;
            end
         end
      end
   endtask

   task automatic drain(input string tag, input int max);
      int k = 0;
      while (pending() != 0 && k < max) begin
         step();
         k++;
      end
      check(tag, pending(), 0);
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < P; i++) begin
         in_data[i] = '0; in_dest[i] = '0; in_last[i] = 1'b0; in_valid[i] = 1'b0;
         out_ready[i] = 1'b1; acc[i] = 1'b0; gap_drv[i] = 1'b0; in_pkt[i] = 1'b0;
         pkt_dest[i] = '0;
      end
      clr_stats();
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", ir_vec, 4'hF);
      check("rst_out_valid", ov_vec, 4'h0);
      check("rst_out_data0", out_data[0], 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // single flit, 2-edge latency
      send(2, 8'hA5, 1, 1'b1);
      step();
      step();
      check("single_acc", acc_cnt[2], 1);
      check("single_not_yet", out_valid[1], 0);
      step();
      check("single_valid", out_valid[1], 1);
      check("single_data", out_data[1], 8'hA5);
      check("single_others", {ov_vec[3:2], ov_vec[0]}, 0);
      check("single_in_ready", ir_vec, 4'hF);
      drain("single_drain", 10);

      // round-robin fairness on output 0
      clr_stats();
      for (int n = 0; n < 2; n++)
         for (int i = 0; i < P; i++) send(i, W'(i * 16 + n), 0, 1'b1);
      drain("rr_drain", 30);
      check("rr_count", hs_cnt[0], 8);
      check("rr_span", last_cyc[0] - first_cyc[0], 7);

      // wormhole lock on output 3
      clr_stats();
      send(1, 8'h11, 3, 1'b0);
      send(1, 8'h12, 3, 1'b0);
      send(1, 8'h13, 3, 1'b1);
      send(2, 8'h21, 3, 1'b1);
      drain("worm_drain", 30);
      check("worm_span", last_cyc[3] - first_cyc[3], 3);
      clr_stats();
      send(1, 8'h14, 3, 1'b0);
      send(1, 8'h15, 3, 1'b0);
      gap(1);
      gap(1);
      send(1, 8'h16, 3, 1'b1);
      send(2, 8'h22, 3, 1'b1);
      drain("stall_drain", 30);
      check("stall_count", hs_cnt[3], 4);
      check("stall_span", last_cyc[3] - first_cyc[3], 5);

      // backpressure and full FIFO on output 0
      clr_stats();
      out_ready[0] = 1'b0;
      for (int n = 0; n < 6; n++) send(0, W'(8'h50 + n), 0, 1'b1);
      for (int k = 0; k < 20 && in_ready[0]; k++) step();
      check("bp_acc_at_full", acc_cnt[0], 5);
      check("bp_in_ready", in_ready[0], 0);
      check("bp_hold_valid", out_valid[0], 1);
      check("bp_hold_data", out_data[0], 8'h50);
      repeat (3) step();
      check("bp_hold_data2", out_data[0], 8'h50);
      check("bp_hold_last", out_last[0], 1);
      check("bp_no_accept", acc_cnt[0], 5);
      out_ready[0] = 1'b1;
      drain("bp_drain", 30);
      check("bp_count", hs_cnt[0], 6);

      // asynchronous reset in the middle of a locked packet
      out_ready[2] = 1'b0;
      send(3, 8'h31, 2, 1'b0);
      send(3, 8'h32, 2, 1'b0);
      send(3, 8'h33, 2, 1'b0);
      repeat (4) step();
      check("pre_rst_valid", out_valid[2], 1);
      #2 rst = 1'b1;
      #1;
      check("rst_async_valid", ov_vec, 4'h0);
      check("rst_async_ready", ir_vec, 4'hF);
      for (int i = 0; i < P; i++) begin
         src_q[i].delete(); exp_q[i].delete();
         in_valid[i] = 1'b0; gap_drv[i] = 1'b0; in_pkt[i] = 1'b0; acc[i] = 1'b0;
      end
      @(negedge clk);
      rst = 1'b0;
      out_ready[2] = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 10; k++) begin
         step();
         check("idle_no_valid", ov_vec, 4'h0);
      end
      send(0, 8'h0C, 2, 1'b1);
      drain("lock_cleared", 10);

      // concurrent permutation, 4 flits per cycle
      clr_stats();
      for (int n = 0; n < 4; n++)
         for (int i = 0; i < P; i++) send(i, W'(8'h80 + i * 16 + n), 3 - i, 1'b1);
      drain("perm_drain", 30);
      check("perm_all_valid", allv_cnt, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
